score_keeper: RTL
=================

# score_keeper

Game-state sequencer that produces the two 4-bit score values consumed by the per-player score digit renderers. It watches the ball column once per video frame, detects goals, increments the scoring player's count, holds play for a fixed number of frames while the ball is re-served, and declares a winner when a player reaches the winning score. It sits between the ball physics block (source of `ball_col`) and the two score display instances (sinks of `score_left` / `score_right`).

## Interface
- `LEFT_GOAL`, 10'd8: `ball_col` at or below this is a goal for the right player.
- `RIGHT_GOAL`, 10'd631: `ball_col` at or above this is a goal for the left player. Must satisfy `LEFT_GOAL < RIGHT_GOAL`.
- `WIN_SCORE`, 4'd9: winning count, legal range 1..9 (one decimal digit).
- `HOLD_FRAMES`, 8'd60: frames frozen after each goal, legal range 1..255.

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame (end of visible area).
- `ball_col`  in  10  current ball left-edge column, valid when `frame_tick` is high.
- `start`  in  1  one-cycle start/restart request.
- `score_left`  out  4  left player score, 0..WIN_SCORE.
- `score_right`  out  4  right player score, 0..WIN_SCORE.
- `ball_reset`  out  1  high while the ball must be held at centre.
- `serve_dir`  out  1  0 = serve toward left, 1 = toward right.
- `game_over`  out  1  high in GAME_OVER.
- `winner`  out  1  0 = left, 1 = right; valid when `game_over`.

## Operation
- States: IDLE, PLAY, HOLD, GAME_OVER. All outputs registered.
- Reset (any state, any cycle): state IDLE, scores 0, hold counter 0, `ball_reset` 1, `serve_dir` 0, `game_over` 0, `winner` 0.
- IDLE: `ball_reset` 1. `start` -> PLAY, `ball_reset` 0.
- PLAY: evaluated only on `frame_tick`. `ball_col <= LEFT_GOAL` -> `score_right`+1, `serve_dir` 0 (serve toward loser = left). `ball_col >= RIGHT_GOAL` -> `score_left`+1, `serve_dir` 1. Either goal: `ball_reset` 1, hold counter loaded with `HOLD_FRAMES-1`, go to HOLD; if the incremented score equals `WIN_SCORE`, go to GAME_OVER instead, `winner` set to scoring side. No goal: stay.
- HOLD: on each `frame_tick`, counter decrements; on `frame_tick` with counter 0 -> PLAY, `ball_reset` 0. Goal conditions ignored in HOLD.
- GAME_OVER: `game_over` 1, `ball_reset` 1, scores frozen. `start` -> scores cleared to 0, `game_over` 0, state PLAY, `ball_reset` 0, `serve_dir` kept.
- `start` ignored in PLAY and HOLD.
- Scores never exceed `WIN_SCORE`; no wrap-around possible.
- `frame_tick` and `start` same cycle in IDLE/GAME_OVER: `start` wins; the tick is not evaluated for goals.

## Timing
- Goal latency: score and `ball_reset` update on the clock edge that samples `frame_tick` high (visible 1 cycle after the tick).
- Hold duration: exactly `HOLD_FRAMES` frame ticks, counting the first tick after entering HOLD; `ball_reset` falls on the edge sampling the last tick.
- `start` -> PLAY in 1 cycle.
- Scores stable for an entire frame; display samples them combinationally without glitch.

## Structure
- Shared package/header: state encoding constants (IDLE=2'd0, PLAY=2'd1, HOLD=2'd2, GAME_OVER=2'd3) and side encoding (LEFT=0, RIGHT=1), reused by ball physics and top level.
- One natural sub-module: `frame_counter`, a loadable down-counter advanced by `frame_tick` with a `zero` flag, used for HOLD.

## Test plan
- Reset then `start`, tick with `ball_col`=320 x10 -> scores stay 0/0, `ball_reset` 0, state PLAY.
- Tick with `ball_col`=5 -> next cycle `score_right`=1, `ball_reset` 1, `serve_dir` 0; with HOLD_FRAMES=3, `ball_reset` falls after exactly 3 further ticks; ticks with `ball_col`=5 during HOLD do not score.
- Tick with `ball_col`=635 -> `score_left`+1, `serve_dir` 1.
- WIN_SCORE=3: left scores 3 times -> after third, `game_over` 1, `winner` 0, `score_left`=3; further ticks at 635 leave scores 3/x.
- In GAME_OVER assert `start` together with `frame_tick` at `ball_col`=0 -> scores 0/0, `game_over` 0, PLAY, no goal counted.
- Assert `reset` in HOLD mid-count with scores 2/1 -> next cycle IDLE, scores 0/0, `ball_reset` 1, `game_over` 0.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared game-state encodings for the score keeper and its neighbours
// (ball physics reuses the side encoding for serve direction).
package score_keeper_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HOLD      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/score_keeper_frame_counter.sv
// Loadable down-counter advanced by frame ticks; saturates at zero.
// Used to time the post-goal hold period in whole frames.
module score_keeper_frame_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/score_keeper.sv
// Game-state sequencer: detects goals once per frame, keeps both scores,
// freezes play for a fixed number of frames after a goal and declares a winner.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter logic [9:0] LEFT_GOAL   = 10'd8,
    parameter logic [9:0] RIGHT_GOAL  = 10'd631,
    parameter logic [3:0] WIN_SCORE   = 4'd9,
    parameter logic [7:0] HOLD_FRAMES = 8'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] ball_col,
    input  logic       start,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output state_t     dbg_state
);

    localparam logic [7:0] HOLD_LOAD = HOLD_FRAMES - 8'd1;

    state_t     state_q;
    logic [3:0] score_left_q;
    logic [3:0] score_right_q;
    logic       ball_reset_q;
    logic       serve_dir_q;
    logic       game_over_q;
    logic       winner_q;

    logic [3:0] score_left_d;
    logic [3:0] score_right_d;
    logic       goal_for_left;
    logic       goal_for_right;
    logic       hold_load;
    logic       hold_tick;
    logic       hold_zero;

    // Ball past the left wall scores for the right player and vice versa.
    assign goal_for_right = (ball_col <= LEFT_GOAL);
    assign goal_for_left  = (ball_col >= RIGHT_GOAL);
    assign score_left_d   = score_left_q + 4'd1;
    assign score_right_d  = score_right_q + 4'd1;

    assign hold_load = (state_q == PLAY) && frame_tick && (goal_for_left || goal_for_right);
    assign hold_tick = (state_q == HOLD) && frame_tick;

    score_keeper_frame_counter #(
        .W(8)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .tick     (hold_tick),
        .zero     (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            ball_reset_q  <= 1'b1;
            serve_dir_q   <= SIDE_LEFT;
            game_over_q   <= 1'b0;
            winner_q      <= SIDE_LEFT;
        end else begin
            case (state_q)
                IDLE: begin
                    ball_reset_q <= 1'b1;
                    if (start) begin
                        state_q      <= PLAY;
                        ball_reset_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (frame_tick && goal_for_right) begin
                        score_right_q <= score_right_d;
                        serve_dir_q   <= SIDE_LEFT;
                        ball_reset_q  <= 1'b1;
                        if (score_right_d == WIN_SCORE) begin
                            state_q     <= GAME_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= SIDE_RIGHT;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (frame_tick && goal_for_left) begin
                        score_left_q <= score_left_d;
                        serve_dir_q  <= SIDE_RIGHT;
                        ball_reset_q <= 1'b1;
                        if (score_left_d == WIN_SCORE) begin
                            state_q     <= GAME_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= SIDE_LEFT;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Counter was loaded with HOLD_FRAMES-1, so the tick seen at zero is the last one.
                    if (frame_tick && hold_zero) begin
                        state_q      <= PLAY;
                        ball_reset_q <= 1'b0;
                    end
                end
                GAME_OVER: begin
                    game_over_q  <= 1'b1;
                    ball_reset_q <= 1'b1;
                    if (start) begin
                        state_q       <= PLAY;
                        score_left_q  <= 4'd0;
                        score_right_q <= 4'd0;
                        game_over_q   <= 1'b0;
                        ball_reset_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign dbg_state   = state_q;

endmodule
